// File: rtl/wr_arbiter4.sv
// Four-requester round-robin write arbiter owning a shared hold-or-load register,
// with bounded lock bursts and a one-cycle acknowledge.
module wr_arbiter4 #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [3:0]       lock,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic [WIDTH-1:0] q,
    output logic [3:0]       ack,
    output logic [1:0]       grant_id,
    output logic             busy
);

    localparam int unsigned CW = 4;

    typedef enum logic {IDLE, BURST} state_t;

    state_t         state, state_n;
    logic [1:0]     ptr, ptr_n;
    logic [1:0]     owner, owner_n;
    logic [CW-1:0]  cnt, cnt_n;

    logic           do_write;
    logic [1:0]     win;
    logic [1:0]     arb_start;
    logic [3:0]     arb_req;
    logic           found;
    logic [1:0]     found_idx;
    logic [WIDTH-1:0] win_data;

    // First asserted request in rotating order from arb_start
    always_comb begin
        found     = 1'b0;
        found_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!found && arb_req[arb_start + 2'(i)]) begin
                found     = 1'b1;
                found_idx = arb_start + 2'(i);
            end
        end
    end

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        owner_n   = owner;
        cnt_n     = cnt;
        do_write  = 1'b0;
        win       = 2'd0;
        arb_start = ptr;
        arb_req   = req;

        if (state == BURST) begin
            // On release the owner is always excluded and search begins after it
            arb_start = owner + 2'd1;
            arb_req   = req & ~(4'b0001 << owner);
        end

        if (state == BURST && req[owner] && cnt < CW'(MAX_BURST)) begin
            do_write = 1'b1;
            win      = owner;
            cnt_n    = cnt + CW'(1);
            if (!lock[owner]) begin
                state_n = IDLE;
                ptr_n   = owner + 2'd1;
            end
        end else if (found) begin
            do_write = 1'b1;
            win      = found_idx;
            if (lock[found_idx]) begin
                state_n = BURST;
                owner_n = found_idx;
                cnt_n   = CW'(1);
            end else begin
                state_n = IDLE;
                ptr_n   = found_idx + 2'd1;
            end
        end else if (state == BURST) begin
            state_n = IDLE;
            ptr_n   = owner + 2'd1;
        end
    end

    always_comb begin
        case (win)
            2'd0:    win_data = d0;
            2'd1:    win_data = d1;
            2'd2:    win_data = d2;
            default: win_data = d3;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 2'd0;
            owner    <= 2'd0;
            cnt      <= '0;
            q        <= '0;
            ack      <= 4'b0000;
            grant_id <= 2'd0;
            busy     <= 1'b0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            owner <= owner_n;
            cnt   <= cnt_n;
            busy  <= (state_n == BURST);
            if (do_write) begin
                q        <= win_data;
                grant_id <= win;
                ack      <= 4'b0001 << win;
            end else begin
                ack <= 4'b0000;
            end
        end
    end

endmodule

// File: tb/tb_wr_arbiter4.sv
// Directed bench for wr_arbiter4: expected outputs are queued per driven cycle
// and compared after the following rising edge.
module tb_wr_arbiter4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] lock;
    logic [7:0] d0, d1, d2, d3;
    logic [7:0] q;
    logic [3:0] ack;
    logic [1:0] grant_id;
    logic       busy;

    int errors = 0;
    int checks = 0;
    logic [14:0] exp_q[$];

    wr_arbiter4 #(.WIDTH(8), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst), .req(req), .lock(lock),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .q(q), .ack(ack), .grant_id(grant_id), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_exp(input logic [7:0] eq, input logic [3:0] ea,
                            input logic [1:0] eg, input logic eb);
        exp_q.push_back({eq, ea, eg, eb});
    endtask

    task automatic compare(input string tag);
        logic [14:0] e;
        logic [14:0] o;
        o = {q, ack, grant_id, busy};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s: scoreboard empty, observed q=%h ack=%b gid=%0d busy=%b",
                   tag, q, ack, grant_id, busy);
        end else begin
            e = exp_q.pop_front();
            assert (o === e) else begin
                errors++;
                $error("FAIL %s: observed q=%h ack=%b gid=%0d busy=%b, expected q=%h ack=%b gid=%0d busy=%b",
                       tag, o[14:7], o[6:3], o[2:1], o[0], e[14:7], e[6:3], e[2:1], e[0]);
            end
        end
    endtask

    // Drive one cycle of inputs at the falling edge, check after the next rising edge
    task automatic step(input string tag, input logic [3:0] r, input logic [3:0] l,
                        input logic [7:0] eq, input logic [3:0] ea,
                        input logic [1:0] eg, input logic eb);
        @(negedge clk);
        rst  = 1'b0;
        req  = r;
        lock = l;
        push_exp(eq, ea, eg, eb);
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        push_exp(8'h00, 4'b0000, 2'd0, 1'b0);
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    initial begin
        rst  = 1'b1;
        req  = 4'b1111;
        lock = 4'b0000;
        d0 = 8'hA0; d1 = 8'hA1; d2 = 8'hA2; d3 = 8'hA3;

        // Reset held with all requesting
        @(posedge clk); #1;
        push_exp(8'h00, 4'b0000, 2'd0, 1'b0);
        compare("reset_hold_a");
        @(posedge clk); #1;
        push_exp(8'h00, 4'b0000, 2'd0, 1'b0);
        compare("reset_hold_b");
        step("first_after_reset", 4'b1111, 4'b0000, 8'hA0, 4'b0001, 2'd0, 1'b0);
        step("idle_hold_a0",      4'b0000, 4'b0000, 8'hA0, 4'b0000, 2'd0, 1'b0);

        // Single requester
        d2 = 8'h5C;
        step("single_r2",         4'b0100, 4'b0000, 8'h5C, 4'b0100, 2'd2, 1'b0);
        d2 = 8'hEE;
        step("single_idle_hold",  4'b0000, 4'b0000, 8'h5C, 4'b0000, 2'd2, 1'b0);

        // Round-robin fairness from a fresh pointer
        do_reset("reset_before_rr");
        d0 = 8'h10; d1 = 8'h11; d2 = 8'h12; d3 = 8'h13;
        step("rr_0",   4'b1111, 4'b0000, 8'h10, 4'b0001, 2'd0, 1'b0);
        step("rr_1",   4'b1111, 4'b0000, 8'h11, 4'b0010, 2'd1, 1'b0);
        step("rr_2",   4'b1111, 4'b0000, 8'h12, 4'b0100, 2'd2, 1'b0);
        step("rr_3",   4'b1111, 4'b0000, 8'h13, 4'b1000, 2'd3, 1'b0);
        step("rr_wrap",4'b1111, 4'b0000, 8'h10, 4'b0001, 2'd0, 1'b0);
        step("rr_idle",4'b0000, 4'b0000, 8'h10, 4'b0000, 2'd0, 1'b0);

        // Burst limit: requester 1 locked, requester 3 waiting
        d1 = 8'h21; d3 = 8'h23;
        step("burst_w1", 4'b1010, 4'b0010, 8'h21, 4'b0010, 2'd1, 1'b1);
        step("burst_w2", 4'b1010, 4'b0010, 8'h21, 4'b0010, 2'd1, 1'b1);
        step("burst_w3", 4'b1010, 4'b0010, 8'h21, 4'b0010, 2'd1, 1'b1);
        step("burst_w4", 4'b1010, 4'b0010, 8'h21, 4'b0010, 2'd1, 1'b1);
        step("burst_forced_r3", 4'b1010, 4'b0010, 8'h23, 4'b1000, 2'd3, 1'b0);
        step("burst_r1_again",  4'b1010, 4'b0010, 8'h21, 4'b0010, 2'd1, 1'b1);
        step("burst_release_none", 4'b0000, 4'b0000, 8'h21, 4'b0000, 2'd1, 1'b0);

        // Early unlock on the third write, pointer moves to 1
        d0 = 8'h30;
        step("unlock_w1", 4'b0001, 4'b0001, 8'h30, 4'b0001, 2'd0, 1'b1);
        d0 = 8'h31;
        step("unlock_w2", 4'b0001, 4'b0001, 8'h31, 4'b0001, 2'd0, 1'b1);
        d0 = 8'h32;
        step("unlock_w3", 4'b0001, 4'b0000, 8'h32, 4'b0001, 2'd0, 1'b0);
        d0 = 8'h40; d1 = 8'h41; d2 = 8'h42; d3 = 8'h43;
        step("unlock_ptr1", 4'b1111, 4'b0000, 8'h41, 4'b0010, 2'd1, 1'b0);
        step("unlock_idle", 4'b0000, 4'b0000, 8'h41, 4'b0000, 2'd1, 1'b0);

        // Asynchronous reset in the middle of a burst (cnt=2)
        d0 = 8'h50;
        step("mid_w1", 4'b0001, 4'b0001, 8'h50, 4'b0001, 2'd0, 1'b1);
        d0 = 8'h51;
        step("mid_w2", 4'b0001, 4'b0001, 8'h51, 4'b0001, 2'd0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        push_exp(8'h00, 4'b0000, 2'd0, 1'b0);
        compare("mid_async_reset");
        d1 = 8'h61; d3 = 8'h63;
        step("post_reset_ptr0", 4'b1010, 4'b0000, 8'h61, 4'b0010, 2'd1, 1'b0);
        step("post_reset_next", 4'b1010, 4'b0000, 8'h63, 4'b1000, 2'd3, 1'b0);

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_drain: observed %0d left, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wr_arbiter4.md
# wr_arbiter4

Four-requester round-robin write arbiter that owns and sequences a shared WIDTH-bit enable-register (hold-or-load flop bank). Each cycle it selects at most one requester, loads that requester's data into the shared register, and returns a one-cycle acknowledge. A lock input lets the current winner hold ownership for a bounded burst. It sits between requesting blocks and any shared configuration or data register built from enable flip-flops.

## Interface
- WIDTH, 8, data and register width in bits
- MAX_BURST, 4, maximum consecutive writes by one locked owner (range 2..15)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req  input  4  per-requester write request, level
- lock  input  4  per-requester burst request, meaningful only together with req
- d0, d1, d2, d3  input  WIDTH each  write data from requesters 0..3
- q  output  WIDTH  shared register contents
- ack  output  4  one-hot, one-cycle pulse; bit i means requester i's data was loaded at the previous edge
- grant_id  output  2  index of the last requester written
- busy  output  1  high while in BURST state

## Operation
- Shared register behaviour:
  - When a write occurs, the register loads the winner's data.
  - Otherwise the register holds (enable-flop semantics).
  - At most one write per cycle.
- Round-robin pointer ptr (2 bits):
  - Search order is ptr, ptr+1, ptr+2, ptr+3, mod 4.
  - The first asserted req wins.
- States:
  - IDLE (no owner)
  - BURST (owner, count cnt)
- IDLE:
  - No req asserted: no write, remain IDLE.
  - Otherwise winner w is written.
    - If lock[w]=1: go to BURST with owner=w, cnt=1.
    - Else: ptr<=w+1, remain IDLE.
- BURST, owner o:
  - req[o]=1 and cnt<MAX_BURST: write o, cnt<=cnt+1.
    - If lock[o]=0 on this write: go to IDLE, ptr<=o+1.
  - req[o]=0: release.
    - Arbitrate this same cycle among the other requesters from o+1.
    - The winner is handled exactly as in IDLE; ptr updated accordingly.
    - If no other req is asserted: go to IDLE, ptr<=o+1, no write.
  - cnt==MAX_BURST with req[o]=1: forced release.
    - Arbitrate from o+1 with o excluded this cycle.
    - If no other req is asserted: no write, go to IDLE, ptr<=o+1.
- grant_id updates only on a write. busy = (state==BURST).
- ack:
  - ack[w]<=1 on the edge that writes w; all other bits go to 0.
  - ack is all-zero after any non-writing edge.
- Requester rules:
  - Hold req and its data stable until ack is seen.
  - req still high in the cycle ack is visible counts as a new request.
- Reset values: q=0, ack=0, grant_id=0, busy=0, state=IDLE, ptr=0, cnt=0.

## Timing
- Arbitration is combinational on req, lock, state, ptr and cnt. All state updates happen on the rising edge.
- Latency:
  - A request sampled at edge k loads q at edge k and raises ack in cycle k+1.
  - Uncontended minimum: one cycle from req to ack.
- Worst-case wait with all four requesting and no locks: 3 cycles.
  - With locks: 3×MAX_BURST cycles.
- Back-to-back writes from different requesters are possible on every edge.
- Asynchronous rst, including mid-burst:
  - Immediately clears all outputs and state, independent of clk.
  - The first write after rst deasserts uses ptr=0.
- Data is sampled only at the write edge. Changes to d on a non-winning requester have no effect.

## Test plan
- Reset: drive req=4'b1111 with rst high → q=0, ack=0, busy=0. Release rst → first write is from requester 0 (d0=8'hA0 → q=8'hA0, ack=4'b0001).
- Single requester: req=4'b0100, d2=8'h5C for one cycle → next cycle q=8'h5C, ack=4'b0100, grant_id=2. Following idle cycle → ack=0, q holds 8'h5C.
- Round-robin fairness: req=4'b1111 held, no locks, d_i=8'h10+i → successive q values 10, 11, 12, 13, 10. ack cycles 0001, 0010, 0100, 1000.
- Burst limit: requester 1 holds req+lock, requester 3 also requesting.
  - Requester 1 is written 4 consecutive cycles with busy=1.
  - Fifth write goes to requester 3, busy=0.
  - Next write is requester 1 again.
- Early unlock: requester 0 locks for 2 writes, then drops lock on the third write → busy falls after the third write, ptr=1.
- Reset mid-burst: assert rst asynchronously between edges during the cnt=2 burst → q, ack, busy go to 0 before the next edge. After release, arbitration restarts from requester 0.
